// File: rtl/div_seq_pkg.sv
// Shared encodings for the RV32M divide sequencer: ALU opcode, divide ops, FSM states.
package div_seq_pkg;

   localparam int DIV_W = 32;

   // Shared ALU opcode; the sequencer only ever asks for a subtract.
   localparam logic [3:0] ALU_SUB = 4'b1000;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SPECIAL = 3'd1,
      S_NEG_A   = 3'd2,
      S_NEG_B   = 3'd3,
      S_ITER    = 3'd4,
      S_FIX     = 3'd5,
      S_DONE    = 3'd6
   } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// Request/response and borrowed-ALU signals between the execute stage and div_seq.
interface div_seq_if;
   import div_seq_pkg::*;

   logic                start;
   div_op_e             op;
   logic [DIV_W-1:0]    dividend;
   logic [DIV_W-1:0]    divisor;
   logic                flush;
   logic                busy;
   logic                done;
   logic [DIV_W-1:0]    result;
   logic                alu_req;
   logic [3:0]          alu_ctrl_o;
   logic [DIV_W-1:0]    alu_a_o;
   logic [DIV_W-1:0]    alu_b_o;
   logic [DIV_W-1:0]    alu_result_i;

   modport slave (
      input  start, op, dividend, divisor, flush, alu_result_i,
      output busy, done, result, alu_req, alu_ctrl_o, alu_a_o, alu_b_o
   );

   modport master (
      output start, op, dividend, divisor, flush, alu_result_i,
      input  busy, done, result, alu_req, alu_ctrl_o, alu_a_o, alu_b_o
   );

endinterface

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: restoring division using the core's shared ALU
// for every subtract/negate, with a fixed 36-cycle latency for the non-special path.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   div_seq_if.slave  bus
);

   div_state_e         state, state_nxt;
   div_op_e            op_r;
   logic [XLEN-1:0]    a_r, b_r;
   logic [XLEN-1:0]    rem, quo, dmag, res_r;
   logic [4:0]         cnt;

   logic [XLEN-1:0]    rp, fix_v, alu_a, alu_b;
   logic               ge, fix_neg, sgn, special, accept, alu_req, done;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   assign sgn     = ~op_r[0];
   assign accept  = bus.start & ~bus.flush;
   assign special = (bus.divisor == '0) ||
                    (~bus.op[0] && bus.dividend == INT_MIN && bus.divisor == '1);

   // The shifted-out remainder MSB is the 33rd compare bit; the ALU handles the wrap.
   assign rp      = {rem[XLEN-2:0], quo[XLEN-1]};
   assign ge      = rem[XLEN-1] | (rp >= dmag);
   assign fix_v   = op_r[1] ? rem : quo;
   assign fix_neg = ((op_r == DIV_OP_DIV) && (a_r[XLEN-1] ^ b_r[XLEN-1])) ||
                    ((op_r == DIV_OP_REM) && a_r[XLEN-1]);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu_req   = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      done      = 1'b0;
      case (state)
         S_IDLE:    if (accept) state_nxt = special ? S_SPECIAL : S_NEG_A;
         S_SPECIAL: state_nxt = S_DONE;
         S_NEG_A: begin
            alu_req   = 1'b1;
            alu_b     = a_r;
            state_nxt = S_NEG_B;
         end
         S_NEG_B: begin
            alu_req   = 1'b1;
            alu_b     = b_r;
            state_nxt = S_ITER;
         end
         S_ITER: begin
            alu_req = 1'b1;
            alu_a   = rp;
            alu_b   = dmag;
            if (cnt == 5'(ITERS-1)) state_nxt = S_FIX;
         end
         S_FIX: begin
            alu_req   = 1'b1;
            alu_b     = fix_v;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = ~bus.flush;
            state_nxt = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
      if (bus.flush && state != S_IDLE) state_nxt = S_IDLE;
   end

   // Flush freezes every datapath register; in IDLE it also blocks accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_r  <= DIV_OP_DIV;
         a_r   <= '0;
         b_r   <= '0;
         rem   <= '0;
         quo   <= '0;
         dmag  <= '0;
         res_r <= '0;
         cnt   <= '0;
      end else if (!bus.flush) begin
         case (state)
            S_IDLE: if (accept) begin
               op_r <= bus.op;
               a_r  <= bus.dividend;
               b_r  <= bus.divisor;
               rem  <= '0;
               quo  <= '0;
               dmag <= '0;
               cnt  <= '0;
            end
            S_SPECIAL: begin
               if (b_r == '0) res_r <= op_r[1] ? a_r : '1;
               else           res_r <= op_r[1] ? '0  : INT_MIN;
            end
            S_NEG_A: quo  <= (sgn && a_r[XLEN-1]) ? bus.alu_result_i : a_r;
            S_NEG_B: dmag <= (sgn && b_r[XLEN-1]) ? bus.alu_result_i : b_r;
            S_ITER: begin
               rem <= ge ? bus.alu_result_i : rp;
               quo <= {quo[XLEN-2:0], ge};
               cnt <= cnt + 5'd1;
            end
            S_FIX:   res_r <= fix_neg ? bus.alu_result_i : fix_v;
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = done;
   assign bus.result     = res_r;
   assign bus.alu_req    = alu_req;
   assign bus.alu_ctrl_o = ALU_SUB;
   assign bus.alu_a_o    = alu_a;
   assign bus.alu_b_o    = alu_b;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed ops push expected results, a monitor checks each done.
module tb_div_seq;
   import div_seq_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
      int          alu;
      string       nm;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst_n;
   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;
   exp_t   q[$];

   div_seq_if bus();

   div_seq #(.XLEN(32), .ITERS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Stand-in for the execute-stage ALU in subtract mode.
   assign bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Monitor: pops on every done and checks value, latency and ALU ownership count.
   initial begin : monitor
      int areq = 0;
      bit sub_bad = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done result=%h", bus.result);
            end else begin
               e = q.pop_front();
               chk({e.nm, " result"}, bus.result, e.res);
               chk({e.nm, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
               chk({e.nm, " alu_req_cycles"}, 32'(areq), 32'(e.alu));
               chk({e.nm, " alu_ctrl_sub"}, 32'(sub_bad), 32'd0);
            end
         end
         if (bus.alu_req === 1'b1) begin
            areq++;
            if (bus.alu_ctrl_o !== ALU_SUB) sub_bad = 1;
         end else if (bus.busy !== 1'b1) begin
            areq = 0;
            sub_bad = 0;
         end
      end
   end

   task automatic issue(input div_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] res, input bit spc, input string nm);
      exp_t e;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.op       = o;
      bus.dividend = a;
      bus.divisor  = b;
      if (push) begin
         e.res = res;
         e.acc = cyc + 1;
         e.lat = spc ? 2 : 36;
         e.alu = spc ? 0 : 35;
         e.nm  = nm;
         q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL timeout_done pending=%0d", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input div_op_e o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input bit spc, input string nm);
      issue(o, a, b, 1'b1, res, spc, nm);
      drain();
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.flush    = 1'b0;
      bus.op       = DIV_OP_DIVU;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      chk("rst busy",    32'(bus.busy),    32'd0);
      chk("rst done",    32'(bus.done),    32'd0);
      chk("rst result",  bus.result,       32'd0);
      chk("rst alu_req", 32'(bus.alu_req), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7");
      run(DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7");
      run(DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2");
      run(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2");
      run(DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, "div_7_m2");
      run(DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2");
      run(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf");
      run(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, "rem_ovf");
      run(DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "divu_5_0");
      run(DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1'b1, "rem_5_0");
      run(DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, "div_min_2");
      run(DIV_OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          1'b0, "divu_carry");
      run(DIV_OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  1'b0, "remu_carry");

      // Flush at the tenth cycle of an operation: no done, result kept.
      issue(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, "flushed");
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush busy",   32'(bus.busy), 32'd0);
      chk("flush done",   32'(bus.done), 32'd0);
      chk("flush result", bus.result,    32'h7FFF_FFFF);
      repeat (40) @(negedge clk);
      chk("flush result_hold", bus.result, 32'h7FFF_FFFF);
      run(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, "divu_9_3");

      // Start together with flush in IDLE is dropped.
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("idle_flush busy", 32'(bus.busy), 32'd0);

      // A start while busy is ignored.
      issue(DIV_OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "divu_ign");
      repeat (5) @(negedge clk);
      bus.start    = 1'b1;
      bus.op       = DIV_OP_DIV;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      repeat (40) @(negedge clk);

      // Reset in the middle of ITER.
      issue(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, "reset_mid");
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst busy",    32'(bus.busy),    32'd0);
      chk("midrst done",    32'(bus.done),    32'd0);
      chk("midrst result",  bus.result,       32'd0);
      chk("midrst alu_req", 32'(bus.alu_req), 32'd0);
      chk("midrst alu_a",   bus.alu_a_o,      32'd0);
      chk("midrst alu_b",   bus.alu_b_o,      32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_after_rst");

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle RV32M divide sequencer that borrows the core's shared 32-bit ALU to execute DIV/DIVU/REM/REMU.
- Sits beside the execute stage. While alu_req is high, the execute-stage ALU input mux selects this block's alu_ctrl_o/alu_a_o/alu_b_o.
- Performs operand negation, 32 restoring-division iterations (ALU does the subtract, block does the compare) and sign fix-up.
- Returns one 32-bit result with a done pulse.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ITERS, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  32  rs1 value
- divisor  in  32  rs2 value
- flush  in  1  pipeline flush; aborts the operation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  32  quotient or remainder
- alu_req  out  1  block owns the ALU this cycle
- alu_ctrl_o  out  4  ALU opcode; always `SUB encoding
- alu_a_o  out  32  ALU operand 1
- alu_b_o  out  32  ALU operand 2
- alu_result_i  in  32  ALU result, combinational, same cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, busy=0, done=0, result=0, alu_req=0, alu_a_o=0, alu_b_o=0, all internal registers 0.
- Priority: reset > flush > normal operation.
- States: IDLE, SPECIAL, NEG_A, NEG_B, ITER, FIX, DONE.
- IDLE, start=1:
  - Latch op and operands.
  - Divisor==0, or signed op with dividend=0x80000000 and divisor=0xFFFFFFFF → SPECIAL.
  - Otherwise → NEG_A.
  - start while busy is ignored and is not queued.
- SPECIAL (1 cycle, ALU not used) → DONE, with:
  - div-by-zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
  - overflow: DIV result 0x80000000; REM result 0.
- NEG_A (1 cycle, alu_req=1): a=0, b=dividend.
  - Store |dividend| = alu_result_i if signed op and dividend[31]=1, else dividend.
- NEG_B (1 cycle): the same rule applied to the divisor, giving D.
  - Both NEG states are always traversed so latency is fixed.
- ITER (ITERS cycles, 5-bit counter):
  - R' = {R[30:0], Q[31]} with carry-out c = R[31].
  - ALU drives a=R'[31:0], b=D.
  - Internal 33-bit compare: ge = c | (R'[31:0] >= D).
  - If ge: R ← alu_result_i. Else R ← R'[31:0].
  - Q ← {Q[30:0], ge}.
  - Counter reaching ITERS-1 → FIX.
- FIX (1 cycle): selected value V = Q for DIV/DIVU, R for REM/REMU.
  - Negate V via the ALU (a=0, b=V) when:
    - DIV and sign(dividend)^sign(divisor)=1, or
    - REM and sign(dividend)=1.
  - result ← negated or plain V.
- DONE (1 cycle): done=1, busy=1, alu_req=0. Then → IDLE.
- result holds until the next operation's DONE/SPECIAL write.
- Latency from the start-accept edge T:
  - normal: done high in cycle T+36.
  - special: done high in cycle T+2.
- alu_req=1 only in NEG_A, NEG_B, ITER, FIX. Otherwise alu_a_o and alu_b_o are driven 0.
- flush=1 in any non-IDLE state: → IDLE on that edge, no done, result unchanged. flush in IDLE has no effect.
- start and flush in the same IDLE cycle: flush wins, the request is dropped.
- Unsigned ops use the operands raw, with no negation.
- The special-case check uses the latched raw operands.

Decomposition:
- Shared core_defines.v:
  - ALU opcode constants; this block uses `SUB.
  - New div op encodings: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
- Local to the module: state encoding localparams (3-bit).
- No sub-module. The ALU operand mux lives in the execute stage, not here.

Test Plan:
- DIVU 100/7 → done at T+36, result 14; REMU 100/7 → 2. alu_req high for exactly 35 cycles and alu_ctrl_o=`SUB throughout.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIV 7/-2 → -3; REM 7/-2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+2; REM of the same → 0; DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
- DIVU 0xFFFFFFFF/0x80000000 → 1, REMU → 0x7FFFFFFF (exercises the carry-out compare path).
- Start DIVU 100/7, assert flush at cycle T+10 → busy=0 next cycle, no done, result keeps its previous value. Then a new start 9/3 → 3 at its own T+36.
- Pulse start during ITER with other operands → ignored, original result correct. Assert rst_n=0 mid-ITER → all outputs 0 the next cycle.
